// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light timing blocks: phase codes, FSM state type, lamp decode.
// Latency: n/a (package only). Backpressure: n/a.
// The lamp decode function is shared with the controller-side checker so both agree on legality.
package tlc_pkg;

  // Decoded phase codes presented on the phase output.
  localparam logic [2:0] PH_OFF = 3'd0;
  localparam logic [2:0] PH_R   = 3'd1;
  localparam logic [2:0] PH_RY  = 3'd2;
  localparam logic [2:0] PH_G   = 3'd3;
  localparam logic [2:0] PH_GY  = 3'd4;
  localparam logic [2:0] PH_BAD = 3'd7;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_COUNT,
    ST_STEP,
    ST_WAIT_ACK,
    ST_FAULT
  } state_t;

  // Map the {red,yellow,green} lamp pattern to a phase code; anything
  // outside the five legal patterns decodes to PH_BAD.
  function automatic logic [2:0] lamp_phase(input logic red, input logic yellow,
                                            input logic green);
    logic [2:0] ph;
    case ({red, yellow, green})
      3'b000:  ph = PH_OFF;
      3'b100:  ph = PH_R;
      3'b110:  ph = PH_RY;
      3'b001:  ph = PH_G;
      3'b011:  ph = PH_GY;
      default: ph = PH_BAD;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Divide-by-PRESCALE tick generator with enable and synchronous clear.
// Latency: tick is combinational, high during the cycle the count sits at PRESCALE-1 with en=1.
// Backpressure: none; en=0 freezes the count without losing the partial period.
// Ports: clk, reset (sync, active-high), en (count enable), clr (sync clear), tick (1-cycle pulse).
module tlc_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_phase_timer.sv
// Dwell-time sequencer: pulses step once the current lamp phase has been held for its tick count.
// Latency: step rises K*PRESCALE+1 cycles after LOAD; illegal/unexpected lamps fault on the next edge.
// Backpressure: enable=0 freezes dwell timing; a controller that ignores step for ACK_MAX cycles faults.
// Ports: clk, reset (sync, active-high), enable, red/yellow/green lamps in; step, phase[2:0],
//        remaining[CNT_W-1:0], fault out; hold in only when TLC_PED_HOLD_EN is defined
//        (holds green at its last tick for pedestrian extension).
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PRESCALE  = 1000,
  parameter int unsigned OFF_TICKS = 1,
  parameter int unsigned RED_TICKS = 30,
  parameter int unsigned RY_TICKS  = 3,
  parameter int unsigned GRN_TICKS = 25,
  parameter int unsigned GY_TICKS  = 4,
  parameter int unsigned ACK_MAX   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
`ifdef TLC_PED_HOLD_EN
  input  logic             hold,
`endif
  output logic             step,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             fault
);

  localparam int ACK_W = $clog2(ACK_MAX + 1) + 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [2:0]       cur_pat;
  logic [CNT_W-1:0] cnt;
  logic [ACK_W-1:0] ack_cnt;
  logic             tick, tick_eff, hold_final;

  // Dwell length per phase; a zero count is widened to one so the
  // counter is never loaded with a value it would underflow from.
  function automatic logic [CNT_W-1:0] dwell_of(input logic [2:0] ph);
    int unsigned t;
    case (ph)
      PH_OFF:  t = OFF_TICKS;
      PH_R:    t = RED_TICKS;
      PH_RY:   t = RY_TICKS;
      PH_G:    t = GRN_TICKS;
      PH_GY:   t = GY_TICKS;
      default: t = 1;
    endcase
    if (t == 0) t = 1;
    return CNT_W'(t);
  endfunction

  assign phase = lamp_phase(red, yellow, green);

  tlc_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   ((state == ST_COUNT) && enable),
    .clr  (state == ST_LOAD),
    .tick (tick)
  );

`ifdef TLC_PED_HOLD_EN
  // Swallow only the tick that would end green; earlier ticks still count
  // down so release lands on the very next tick.
  assign hold_final = hold && (cur_pat == PH_G) && (cnt == CNT_ONE);
`else
  assign hold_final = 1'b0;
`endif

  assign tick_eff = tick && !hold_final;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Pattern checks come before tick checks so a lamp
  // change coinciding with a tick faults rather than stepping.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        state_nxt = (phase == PH_BAD) ? ST_FAULT : ST_COUNT;
      end
      ST_COUNT: begin
        if (phase != cur_pat) begin
          state_nxt = ST_FAULT;
        end else if (tick_eff && (cnt == CNT_ONE)) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        state_nxt = (phase == PH_BAD) ? ST_FAULT : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (phase == PH_BAD) begin
          state_nxt = ST_FAULT;
        end else if (phase != cur_pat) begin
          state_nxt = ST_LOAD;
        end else if (ack_cnt >= ACK_LAST) begin
          state_nxt = ST_FAULT;
        end
      end
      default: begin
        state_nxt = ST_FAULT;
      end
    endcase
  end

  // Datapath: latched pattern, dwell counter, ack timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_pat <= PH_OFF;
      cnt     <= '0;
      ack_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          cur_pat <= phase;
          cnt     <= dwell_of(phase);
        end
        ST_COUNT: begin
          if (tick_eff && (phase == cur_pat)) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STEP: begin
          // The step cycle itself counts toward the ACK_MAX budget.
          ack_cnt <= ACK_W'(1);
        end
        ST_WAIT_ACK: begin
          ack_cnt <= ack_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    step      = (state == ST_STEP);
    fault     = (state == ST_FAULT);
    remaining = (state == ST_COUNT) ? cnt : '0;
  end

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Scoreboard bench for tlc_phase_timer: stimulus queues timed expectations, the monitor checks them.
// Small parameters: PRESCALE=4, ticks OFF=1 R=3 RY=2 G=3 GY=2, ACK_MAX=8.
// Hold scenario is compiled in only when TLC_PED_HOLD_EN is defined.
`timescale 1ns/1ps
module tb_tlc_phase_timer;

  localparam int P = 4;
  localparam int KT[5] = '{1, 3, 2, 3, 2};  // ticks indexed by phase code

  typedef enum int {F_STEP, F_FAULT, F_REM, F_PHASE} field_e;
  typedef struct {
    int     cyc;
    field_e fld;
    int     val;
    string  name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0;
`ifdef TLC_PED_HOLD_EN
  logic        hold = 1'b0;
`endif
  logic        step;
  logic [2:0]  phase;
  logic [15:0] remaining;
  logic        fault;

  exp_t exp_q[$];
  bit   seen[int];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   done = 1'b0;

  tlc_phase_timer #(
    .CNT_W(16), .PRESCALE(P), .OFF_TICKS(1), .RED_TICKS(3), .RY_TICKS(2),
    .GRN_TICKS(3), .GY_TICKS(2), .ACK_MAX(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
`ifdef TLC_PED_HOLD_EN
    .hold     (hold),
`endif
    .step     (step),
    .phase    (phase),
    .remaining(remaining),
    .fault    (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input field_e f, input int v, input string n);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic set_lamps(input logic [2:0] l);
    {red, yellow, green} = l;
  endtask

  // Returns L, the edge that put the DUT into LOAD with lamps l.
  task automatic do_reset(input logic [2:0] l, output int L);
    @(posedge clk); #2;
    reset = 1'b1;
    set_lamps(l);
    @(posedge clk); #2;
    reset = 1'b0;
    L = cyc;
  endtask

  // Behavioural controller: advances its lamps on every step pulse.
  task automatic run_ctrl(input int until_cyc);
    while (cyc < until_cyc) begin
      @(posedge clk); #2;
      if (step) begin
        case ({red, yellow, green})
          3'b000:  set_lamps(3'b100);
          3'b100:  set_lamps(3'b110);
          3'b110:  set_lamps(3'b001);
          3'b001:  set_lamps(3'b011);
          default: set_lamps(3'b100);
        endcase
      end
    end
  endtask

  // Monitor: every cycle, compare all expectations due now.
  always @(negedge clk) begin
    bit step_ok;
    int act;
    step_ok = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!seen.exists(i) && exp_q[i].cyc <= cyc) begin
        seen[i] = 1'b1;
        n_total++;
        case (exp_q[i].fld)
          F_STEP:  act = int'(step);
          F_FAULT: act = int'(fault);
          F_REM:   act = int'(remaining);
          default: act = int'(phase);
        endcase
        if (exp_q[i].cyc < cyc) begin
          $display("FAIL %s: due at cycle %0d, not sampled until %0d", exp_q[i].name, exp_q[i].cyc, cyc);
        end else if (act == exp_q[i].val) begin
          n_pass++;
          if (exp_q[i].fld == F_STEP && exp_q[i].val == 1) step_ok = 1'b1;
        end else begin
          $display("FAIL %s @cyc %0d: got %0d, expected %0d", exp_q[i].name, cyc, act, exp_q[i].val);
        end
      end
    end
    if (step === 1'b1 && !step_ok) begin
      n_total++;
      $display("FAIL unexpected_step @cyc %0d: step=1, expected 0", cyc);
    end
    if (done) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (!seen.exists(i)) begin
          n_total++;
          $display("FAIL %s: due at cycle %0d, never checked", exp_q[i].name, exp_q[i].cyc);
        end
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
      $fatal(1);
    end
  end

  initial begin
    int L, L2, t, c, ph;

    // Reset state with lamps off.
    set_lamps(3'b000);
    repeat (3) @(posedge clk);
    #2;
    c = cyc;
    expect_at(c, F_STEP,  0, "rst_step");
    expect_at(c, F_REM,   0, "rst_remaining");
    expect_at(c, F_FAULT, 0, "rst_fault");
    expect_at(c, F_PHASE, 0, "rst_phase");

    // Red held: step 13 cycles after LOAD, remaining 3,2,1,0; no ack -> fault 8 later.
    do_reset(3'b100, L);
    expect_at(L + 1,  F_PHASE, 1, "red_phase");
    expect_at(L + 1,  F_REM,   3, "red_rem3");
    expect_at(L + 5,  F_REM,   2, "red_rem2");
    expect_at(L + 9,  F_REM,   1, "red_rem1");
    expect_at(L + 12, F_STEP,  0, "red_step_early");
    expect_at(L + 13, F_STEP,  1, "red_step");
    expect_at(L + 13, F_REM,   0, "red_rem0");
    expect_at(L + 14, F_STEP,  0, "red_step_width");
    expect_at(L + 20, F_FAULT, 0, "red_ack_nofault");
    expect_at(L + 21, F_FAULT, 1, "red_ack_fault");
    wait_cyc(L + 24);

    // Green stuck (controller ignores step): fault 8 cycles after step.
    do_reset(3'b001, L);
    expect_at(L + 1,  F_REM,   3, "grn_rem3");
    expect_at(L + 13, F_STEP,  1, "grn_step");
    expect_at(L + 20, F_FAULT, 0, "grn_ack_nofault");
    expect_at(L + 21, F_FAULT, 1, "grn_ack_fault");
    expect_at(L + 21, F_PHASE, 3, "grn_fault_phase");
    wait_cyc(L + 24);

    // Full legal sequence: OFF then three R,RY,G,GY cycles; controller acks in 1 cycle.
    do_reset(3'b000, L);
    t = L;
    for (int i = 0; i < 13; i++) begin
      ph = (i == 0) ? 0 : ((i - 1) % 4) + 1;
      expect_at(t + 1, F_PHASE, ph, "seq_phase");
      expect_at(t + KT[ph] * P + 1, F_STEP, 1, "seq_step");
      t = t + KT[ph] * P + 3;
    end
    expect_at(t + 1, F_PHASE, 1, "seq_wrap_phase");
    expect_at(t + 2, F_FAULT, 0, "seq_nofault");
    run_ctrl(t + 3);

    // Illegal lamps mid-COUNT: phase 7 at once, fault next edge, absorbing.
    c = cyc;
    set_lamps(3'b111);
    expect_at(c,      F_PHASE, 7, "bad_phase");
    expect_at(c,      F_FAULT, 0, "bad_fault_pre");
    expect_at(c + 1,  F_FAULT, 1, "bad_fault");
    expect_at(c + 1,  F_REM,   0, "bad_rem");
    expect_at(c + 30, F_FAULT, 1, "bad_fault_sticky");
    wait_cyc(c + 31);
    do_reset(3'b000, L);
    expect_at(L, F_FAULT, 0, "postrst_fault");
    expect_at(L, F_STEP,  0, "postrst_step");
    expect_at(L, F_REM,   0, "postrst_rem");
    expect_at(L, F_PHASE, 0, "postrst_phase");

    // enable low 10 cycles mid-red: step moves from L+13 to L+23.
    do_reset(3'b100, L);
    expect_at(L + 13, F_STEP, 0, "en_step_not_early");
    expect_at(L + 15, F_REM,  2, "en_rem_frozen");
    expect_at(L + 22, F_STEP, 0, "en_step_early");
    expect_at(L + 23, F_STEP, 1, "en_step");
    wait_cyc(L + 6);
    enable = 1'b0;
    wait_cyc(L + 16);
    enable = 1'b1;
    wait_cyc(L + 24);

    // Reset mid-count: dwell restarts from RED_TICKS.
    do_reset(3'b100, L);
    L2 = L + 7;
    expect_at(L + 6,  F_REM,  2, "rstmid_rem2");
    expect_at(L + 7,  F_REM,  0, "rstmid_load");
    expect_at(L2 + 1, F_REM,  3, "rstmid_rem3");
    expect_at(L + 13, F_STEP, 0, "rstmid_old_step");
    expect_at(L2 + 13, F_STEP, 1, "rstmid_step");
    wait_cyc(L + 6);
    reset = 1'b1;
    wait_cyc(L + 7);
    reset = 1'b0;
    wait_cyc(L2 + 14);

`ifdef TLC_PED_HOLD_EN
    // Hold through green: no step until release, then step on the next tick.
    hold = 1'b1;
    do_reset(3'b001, L);
    expect_at(L + 9,  F_REM,  1, "hold_rem1");
    expect_at(L + 13, F_STEP, 0, "hold_no_step");
    expect_at(L + 29, F_REM,  1, "hold_rem_held");
    expect_at(L + 33, F_STEP, 1, "hold_release_step");
    wait_cyc(L + 30);
    hold = 1'b0;
    wait_cyc(L + 35);
`endif

    wait_cyc(cyc + 3);
    done = 1'b1;
  end

endmodule
